// File: rtl/block_scale_shift.sv
// block_scale_shift
//
// Block-floating-point scaler. Each incoming packet is stored in one bank of
// a two-bank (ping-pong) buffer. When the packet's OR-envelope max arrives,
// one shared shift is derived from it. The packet is then replayed as OW-bit
// signed IQ, together with that shift.
//
// Ports
//   clk                   sole clock
//   rst                   asynchronous reset, active low
//   i_sop/i_eop/i_vld     input framing (sop/eop qualified by vld)
//   i_din_re/i_din_im     IW-bit two's-complement input samples
//   i_max                 OR-envelope of |x| for the packet
//   i_max_vld             one-cycle strobe for i_max
//   o_sop/o_eop/o_vld     output framing
//   o_dout_re/o_dout_im   OW-bit scaled samples
//   o_shift               shift of the current output packet
//   o_err                 one-cycle error pulse
//
// Optional feature macro: BLOCK_SCALE_RND_EN
//   defined   : round half up, then saturate to OW bits
//   undefined : arithmetic shift with plain truncation (floor)
//
// Bank states
//   state       | meaning
//   B_EMPTY     | free, may accept the next packet
//   B_FILLING   | packet being written
//   B_WAIT_MAX  | packet closed, waiting for its max strobe
//   B_READY     | shift latched, queued for readout
//   B_READING   | addresses being issued to the RAM
//
// Read FSM states
//   state       | meaning
//   RD_IDLE     | no bank streaming; address 0 of a READY bank is issued
//               | in this same cycle, so there is no dead cycle between
//               | packets
//   RD_READ     | issuing addresses 1..len-1 of the current bank

module block_scale_shift #(
    parameter int IW      = 40,
    parameter int OW      = 16,
    parameter int MAX_LEN = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_sop,
    input  logic          i_eop,
    input  logic          i_vld,
    input  logic [IW-1:0] i_din_re,
    input  logic [IW-1:0] i_din_im,
    input  logic [IW-1:0] i_max,
    input  logic          i_max_vld,
    output logic          o_sop,
    output logic          o_eop,
    output logic          o_vld,
    output logic [OW-1:0] o_dout_re,
    output logic [OW-1:0] o_dout_im,
    output logic [5:0]    o_shift,
    output logic          o_err
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        B_EMPTY,
        B_FILLING,
        B_WAIT_MAX,
        B_READY,
        B_READING
    } bank_t;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_t;

    bank_t         bank_st  [2];
    bank_t         bank_nxt [2];
    logic [LW-1:0] len_r    [2];
    logic [5:0]    shift_r  [2];

    logic          wbank, mbank, rbank;
    logic [LW-1:0] wcnt;
    logic          ovf_seen;
    logic [1:0]    skip_cnt;

    // shift = p+2-OW where p is the MSB index of the max; 0 when max is 0
    function automatic logic [5:0] calc_shift(input logic [IW-1:0] m);
        int p;
        p = -1;
        for (int i = 0; i < IW; i++) begin
            if (m[i]) p = i;
        end
        if (p + 2 > OW) return 6'(p + 2 - OW);
        else            return 6'd0;
    endfunction

`ifdef BLOCK_SCALE_RND_EN
    localparam logic signed [IW:0] SAT_MAX = {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] SAT_MIN = {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};

    function automatic logic [OW-1:0] scale(input logic [IW-1:0] x, input logic [5:0] sh);
        logic signed [IW:0] xe, rnd, y;
        xe  = signed'({x[IW-1], x});
        rnd = '0;
        if (sh != 6'd0) rnd = signed'({{IW{1'b0}}, 1'b1} << (sh - 6'd1));
        y = (xe + rnd) >>> sh;
        if (y > SAT_MAX)      return OW'(SAT_MAX);
        else if (y < SAT_MIN) return OW'(SAT_MIN);
        else                  return OW'(y);
    endfunction
`else
    // |x| < 2^(p+1), so after the shift the value always fits in OW bits
    function automatic logic [OW-1:0] scale(input logic [IW-1:0] x, input logic [5:0] sh);
        logic signed [IW-1:0] y;
        y = signed'(x) >>> sh;
        return OW'(y);
    endfunction
`endif

    // ---------------- write side decode ----------------
    logic          w_filling, w_free;
    logic          wr_start, wr_restart, wr_drop, wr_cont, wr_keep;
    logic          wr_en, wr_close, wr_ovf;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] wr_len;

    always_comb begin
        w_filling  = (bank_st[wbank] == B_FILLING);
        w_free     = (bank_st[wbank] == B_EMPTY) || w_filling;
        wr_start   = i_vld & i_sop & w_free;
        wr_restart = i_vld & i_sop & w_filling;
        wr_drop    = i_vld & i_sop & ~w_free;
        wr_cont    = i_vld & ~i_sop & w_filling;
        wr_keep    = wr_cont & (wcnt != LEN_MAX);
        wr_en      = wr_start | wr_keep;
        wr_ovf     = wr_cont & ~wr_keep & ~ovf_seen;
        wr_close   = (wr_start | wr_cont) & i_eop;
        wr_addr    = wr_start ? '0 : wcnt[AW-1:0];
        if (wr_start)     wr_len = LW'(1);
        else if (wr_keep) wr_len = wcnt + LW'(1);
        else              wr_len = LEN_MAX;
    end

    // ---------------- max strobe decode ----------------
    // Strobes belonging to dropped packets are absorbed silently by skip_cnt.
    logic       max_hit, max_skip, max_err;
    logic [5:0] max_shift;

    always_comb begin
        max_hit   = i_max_vld & (bank_st[mbank] == B_WAIT_MAX);
        max_skip  = i_max_vld & ~max_hit & (skip_cnt != 2'd0);
        max_err   = i_max_vld & ~max_hit & (skip_cnt == 2'd0);
        max_shift = calc_shift(i_max);
    end

    // ---------------- read FSM ----------------
    rd_t           rd_state, rd_nxt;
    logic [AW-1:0] raddr;
    logic          rd_go, rd_issue, rd_first, rd_last;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_state <= RD_IDLE;
        else      rd_state <= rd_nxt;
    end

    always_comb begin
        rd_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (rd_go && !rd_last) rd_nxt = RD_READ;
            RD_READ: if (rd_last)           rd_nxt = RD_IDLE;
            default:                        rd_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_go    = (bank_st[rbank] == B_READY);
        rd_first = (rd_state == RD_IDLE) & rd_go;
        rd_issue = (rd_state == RD_READ) | rd_first;
        rd_addr  = (rd_state == RD_IDLE) ? '0 : raddr;
        rd_last  = rd_issue & ({1'b0, rd_addr} == len_r[rbank] - LW'(1));
    end

    // ---------------- bank state next ----------------
    // Write, max and read only act on banks in mutually exclusive states,
    // so the three updates never collide on the same bank.
    always_comb begin
        bank_nxt = bank_st;
        if (wr_start) bank_nxt[wbank] = B_FILLING;
        if (wr_close) bank_nxt[wbank] = B_WAIT_MAX;
        if (max_hit)  bank_nxt[mbank] = B_READY;
        if (rd_first) bank_nxt[rbank] = B_READING;
        if (rd_last)  bank_nxt[rbank] = B_EMPTY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= B_EMPTY;
                len_r[b]   <= '0;
                shift_r[b] <= '0;
            end
            wbank    <= 1'b0;
            mbank    <= 1'b0;
            rbank    <= 1'b0;
            wcnt     <= '0;
            ovf_seen <= 1'b0;
            skip_cnt <= '0;
            raddr    <= '0;
            o_err    <= 1'b0;
        end else begin
            bank_st <= bank_nxt;
            if (wr_start) begin
                wcnt     <= LW'(1);
                ovf_seen <= 1'b0;
            end else if (wr_keep) begin
                wcnt <= wcnt + LW'(1);
            end
            if (wr_ovf) ovf_seen <= 1'b1;
            if (wr_close) begin
                len_r[wbank] <= wr_len;
                wbank        <= ~wbank;
            end
            if (max_hit) begin
                shift_r[mbank] <= max_shift;
                mbank          <= ~mbank;
            end
            if (wr_drop && !max_skip && skip_cnt != 2'd3) skip_cnt <= skip_cnt + 2'd1;
            else if (max_skip && !wr_drop)                skip_cnt <= skip_cnt - 2'd1;
            if (rd_issue) raddr <= rd_addr + AW'(1);
            if (rd_last)  rbank <= ~rbank;
            o_err <= wr_drop | wr_restart | wr_ovf | max_err;
        end
    end

    // ---------------- sample RAM (contents survive reset) ----------------
    logic [2*IW-1:0] mem [2*MAX_LEN];
    logic [2*IW-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (wr_en)    mem[{wbank, wr_addr}] <= {i_din_re, i_din_im};
        if (rd_issue) rd_data <= mem[{rbank, rd_addr}];
    end

    // ---------------- output pipeline ----------------
    logic       p1_vld, p1_sop, p1_eop;
    logic [5:0] p1_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_vld    <= 1'b0;
            p1_sop    <= 1'b0;
            p1_eop    <= 1'b0;
            p1_shift  <= '0;
            o_vld     <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            o_dout_re <= '0;
            o_dout_im <= '0;
            o_shift   <= '0;
        end else begin
            p1_vld   <= rd_issue;
            p1_sop   <= rd_first;
            p1_eop   <= rd_last;
            p1_shift <= shift_r[rbank];
            o_vld    <= p1_vld;
            o_sop    <= p1_vld & p1_sop;
            o_eop    <= p1_vld & p1_eop;
            if (p1_vld) begin
                o_dout_re <= scale(rd_data[2*IW-1:IW], p1_shift);
                o_dout_im <= scale(rd_data[IW-1:0], p1_shift);
            end else begin
                o_dout_re <= '0;
                o_dout_im <= '0;
            end
            if (p1_vld && p1_sop) o_shift <= p1_shift;
        end
    end

endmodule

// File: tb/tb_block_scale_shift.sv
// Directed bench for block_scale_shift with IW=40, OW=16, MAX_LEN=1024.

module tb_block_scale_shift;

    localparam int IW      = 40;
    localparam int OW      = 16;
    localparam int MAX_LEN = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_sop, i_eop, i_vld, i_max_vld;
    logic [IW-1:0] i_din_re, i_din_im, i_max;
    logic          o_sop, o_eop, o_vld, o_err;
    logic [OW-1:0] o_dout_re, o_dout_im;
    logic [5:0]    o_shift;

    block_scale_shift #(.IW(IW), .OW(OW), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst),
        .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
        .i_din_re(i_din_re), .i_din_im(i_din_im),
        .i_max(i_max), .i_max_vld(i_max_vld),
        .o_sop(o_sop), .o_eop(o_eop), .o_vld(o_vld),
        .o_dout_re(o_dout_re), .o_dout_im(o_dout_im),
        .o_shift(o_shift), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] re;
        logic [OW-1:0] im;
        logic [5:0]    sh;
        logic          sop;
        logic          eop;
        int            cyc;
    } out_t;

    out_t q[$];
    int   err_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (o_vld) q.push_back('{o_dout_re, o_dout_im, o_shift, o_sop, o_eop, cyc});
            if (o_err) err_cnt++;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int t_max = 0;
    int e0, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic out_t at(input int k);
        out_t r;
        if (k < q.size()) return q[k];
        r.re = 'x; r.im = 'x; r.sh = 'x; r.sop = 1'bx; r.eop = 1'bx; r.cyc = -1;
        return r;
    endfunction

    task automatic step(input logic sop, input logic eop, input logic vld,
                        input logic [IW-1:0] re, input logic [IW-1:0] im,
                        input logic mv, input logic [IW-1:0] mx);
        i_sop = sop; i_eop = eop; i_vld = vld;
        i_din_re = re; i_din_im = im;
        i_max_vld = mv; i_max = mx;
        if (mv) t_max = cyc;
        @(posedge clk); #1;
        i_sop = 0; i_eop = 0; i_vld = 0; i_din_re = 0; i_din_im = 0;
        i_max_vld = 0; i_max = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_out(input int n, input int budget);
        int k;
        k = 0;
        while (q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_sop = 0; i_eop = 0; i_vld = 0; i_din_re = 0; i_din_im = 0;
        i_max_vld = 0; i_max = 0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        chk("rst_vld",   o_vld, 0);
        chk("rst_sop",   o_sop, 0);
        chk("rst_eop",   o_eop, 0);
        chk("rst_re",    o_dout_re, 0);
        chk("rst_im",    o_dout_im, 0);
        chk("rst_shift", o_shift, 0);
        chk("rst_err",   o_err, 0);
        rst = 1;
        idle(2);

        // 1: basic scaling, shift 17
        q.delete(); e0 = err_cnt;
        step(1, 0, 1, 40'h0080000000, 0, 0, 0);
        step(0, 0, 1, 40'hFF80000000, 0, 0, 0);
        step(0, 0, 1, 40'h0000000123, 0, 0, 0);
        step(0, 1, 1, 40'h0000000000, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h0080000000);
        wait_out(4, 20); idle(3);
        chk("t1_count", q.size(), 4);
        chk("t1_sop",   at(0).sop, 1);
        chk("t1_sop_t", at(0).cyc, t_max + 3);
        chk("t1_re0",   at(0).re, 16'h4000);
        chk("t1_re1",   at(1).re, 16'hC000);
        chk("t1_re2",   at(2).re, 16'h0000);
        chk("t1_re3",   at(3).re, 16'h0000);
        chk("t1_im0",   at(0).im, 16'h0000);
        chk("t1_sh0",   at(0).sh, 17);
        chk("t1_sh3",   at(3).sh, 17);
        chk("t1_eop",   at(3).eop, 1);
        chk("t1_eop_t", at(3).cyc, t_max + 6);
        chk("t1_err",   err_cnt - e0, 0);

        // 2: small max, shift 0, values pass through
        q.delete(); e0 = err_cnt;
        step(1, 0, 1, 40'h0000001234, 40'h0000001000, 0, 0);
        step(0, 0, 1, 40'hFFFFFFEDCC, 40'h0000000000, 0, 0);
        step(0, 0, 1, 40'h0000000FFF, 40'hFFFFFFF000, 0, 0);
        step(0, 1, 1, 40'hFFFFFFFFFF, 40'h0000000001, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h0000001234);
        wait_out(4, 20); idle(3);
        chk("t2_count", q.size(), 4);
        chk("t2_sh",    at(0).sh, 0);
        chk("t2_re0",   at(0).re, 16'h1234);
        chk("t2_re1",   at(1).re, 16'hEDCC);
        chk("t2_re2",   at(2).re, 16'h0FFF);
        chk("t2_re3",   at(3).re, 16'hFFFF);
        chk("t2_im0",   at(0).im, 16'h1000);
        chk("t2_im2",   at(2).im, 16'hF000);
        chk("t2_im3",   at(3).im, 16'h0001);

        // 3: back-to-back packets, shift 9 then 17
        q.delete(); e0 = err_cnt;
        for (int i = 0; i < 8; i++)
            step(i == 0, i == 7, 1, IW'(i + 1) << 20, -(IW'(i + 1) << 20), 0, 0);
        for (int i = 0; i < 8; i++)
            step(i == 0, i == 7, 1, IW'(i + 1) << 28, IW'(i) << 26, i == 1, 40'h0000F00000);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h00FC000000);
        wait_out(16, 40); idle(5);
        chk("t3_count",  q.size(), 16);
        chk("t3_contig", at(15).cyc - at(0).cyc, 15);
        chk("t3_sopA",   at(0).sop, 1);
        chk("t3_eopA",   at(7).eop, 1);
        chk("t3_sopB",   at(8).sop, 1);
        chk("t3_eopB",   at(15).eop, 1);
        chk("t3_shA",    at(0).sh, 9);
        chk("t3_shA_end", at(7).sh, 9);
        chk("t3_shB",    at(8).sh, 17);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (at(i).re !== 16'((i + 1) << 11))      bad++;
            if (at(i).im !== 16'(-((i + 1) << 11)))   bad++;
            if (at(i + 8).re !== 16'((i + 1) << 11))  bad++;
            if (at(i + 8).im !== 16'(i << 9))         bad++;
        end
        chk("t3_data", bad, 0);
        chk("t3_err",  err_cnt - e0, 0);

        // 4: third packet while both banks wait for max
        q.delete(); e0 = err_cnt;
        for (int i = 0; i < 4; i++) step(i == 0, i == 3, 1, IW'((i + 1) * 'h100), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(i == 0, i == 3, 1, -(IW'(i + 1) << 24), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(i == 0, i == 3, 1, 40'h5555, 40'h5555, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h0000000700);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h0007000000);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h0000005555);
        wait_out(8, 30); idle(8);
        chk("t4_count", q.size(), 8);
        chk("t4_err",   err_cnt - e0, 1);
        chk("t4_shD",   at(4).sh, 12);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (at(i).re !== 16'((i + 1) * 'h100))      bad++;
            if (at(i + 4).re !== 16'(-((i + 1) << 12))) bad++;
        end
        chk("t4_data", bad, 0);

        // 5a: overlong packet truncated to MAX_LEN
        q.delete(); e0 = err_cnt;
        for (int i = 0; i < 1030; i++) step(i == 0, i == 1029, 1, IW'(i), 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h00000007FF);
        wait_out(1024, 1100); idle(5);
        chk("t5_count", q.size(), 1024);
        chk("t5_eop",   at(1023).eop, 1);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (at(i).re !== 16'(i) || at(i).im !== 16'h0) bad++;
        chk("t5_data", bad, 0);
        chk("t5_err",  err_cnt - e0, 1);

        // 5b: stray samples, stray max, then sop mid-fill
        q.delete(); e0 = err_cnt;
        step(0, 0, 1, 40'h999, 0, 0, 0);
        step(0, 0, 1, 40'h999, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 40'h1);
        idle(1);
        chk("t5_stray_err", err_cnt - e0, 1);
        step(1, 0, 1, 40'h111, 0, 0, 0);
        step(0, 0, 1, 40'h112, 0, 0, 0);
        step(0, 0, 1, 40'h113, 0, 0, 0);
        step(1, 0, 1, 40'h222, 0, 0, 0);
        step(0, 1, 1, 40'h223, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h223);
        wait_out(2, 20); idle(5);
        chk("t5_rs_count", q.size(), 2);
        chk("t5_rs_re0",   at(0).re, 16'h0222);
        chk("t5_rs_re1",   at(1).re, 16'h0223);
        chk("t5_rs_err",   err_cnt - e0, 2);

        // rounding / truncation at shift 4, then single-sample packet
        q.delete();
        step(1, 0, 1, 40'h000007FFFF, 0, 0, 0);
        step(0, 0, 1, 40'h0000000018, 0, 0, 0);
        step(0, 1, 1, 40'hFFFFF80001, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h000007FFFF);
        wait_out(3, 20); idle(3);
        chk("rnd_sh",  at(0).sh, 4);
        chk("rnd_re0", at(0).re, 16'h7FFF);
`ifdef BLOCK_SCALE_RND_EN
        chk("rnd_re1", at(1).re, 16'h0002);
`else
        chk("rnd_re1", at(1).re, 16'h0001);
`endif
        chk("rnd_re2", at(2).re, 16'h8000);
        q.delete();
        step(1, 1, 1, 40'h55, 40'h2A, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h7F);
        wait_out(1, 20); idle(3);
        chk("one_count", q.size(), 1);
        chk("one_sop",   at(0).sop, 1);
        chk("one_eop",   at(0).eop, 1);
        chk("one_re",    at(0).re, 16'h0055);
        chk("one_im",    at(0).im, 16'h002A);

        // 6: reset in the middle of a readout
        q.delete();
        for (int i = 0; i < 8; i++) step(i == 0, i == 7, 1, IW'(i + 1) << 20, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'h0000F00000);
        wait_out(3, 20);
        chk("t6_pre_vld",   o_vld, 1);
        chk("t6_pre_shift", o_shift, 9);
        rst = 0;
        #1;
        chk("t6_vld",   o_vld, 0);
        chk("t6_sop",   o_sop, 0);
        chk("t6_eop",   o_eop, 0);
        chk("t6_re",    o_dout_re, 0);
        chk("t6_shift", o_shift, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        q.delete();
        idle(20);
        chk("t6_residual", q.size(), 0);
        step(1, 1, 1, 40'hABC, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 40'hABC);
        wait_out(1, 20); idle(3);
        chk("t6_after_count", q.size(), 1);
        chk("t6_after_re",    at(0).re, 16'h0ABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
